// File: rtl/ccff_loader_pkg.sv
// Shared state encoding, CRC-16 constants and the serial CRC step function
// used by the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } ccff_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One bit of an MSB-first CRC-16 register update.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// One-bit-per-cycle CRC-16 accumulator with synchronous clear and enable.
// crc_next exposes the value the register would take if din were consumed this cycle.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc,
  output logic [15:0] crc_next
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_next = crc16_step(crc_q, din);
    if (clr) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = crc_next;
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain driver: parallel words in, LSB-first bits out on ccff_head.
// Define CCFF_READBACK_EN to add a circulating CRC-16 readback check after the load.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 48,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_fail
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int REM_W  = $clog2(DATA_W);
  localparam int TAKE_W = $clog2(DATA_W + 1);
  localparam int MW     = (CNT_W > TAKE_W) ? CNT_W : TAKE_W;

  localparam logic [MW-1:0]    CHAIN_LEN_M = MW'(CHAIN_LEN);
  localparam logic [MW-1:0]    DATA_W_M    = MW'(DATA_W);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(CHAIN_LEN - 1);

  ccff_state_e       state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [REM_W-1:0]  word_rem_q, word_rem_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept_s;
  logic              start_ok_s;
  logic              last_shift_s;
  logic [MW-1:0]     left_s;
  logic [MW-1:0]     take_s;

  // The final word only contributes the bits still missing from the chain.
  always_comb begin
    accept_s     = (state_q == ST_LOAD) && cfg_valid && ready_q;
    start_ok_s   = (state_q == ST_IDLE) && start;
    last_shift_s = shift_en_q && (bit_cnt_q == LAST_IDX);
    left_s       = CHAIN_LEN_M - MW'(acc_q);
    take_s       = (left_s > DATA_W_M) ? DATA_W_M : left_s;
  end

`ifdef CCFF_READBACK_EN
  logic crc_fail_s;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    word_rem_d = word_rem_q;
    sreg_d     = sreg_q;
    head_d     = 1'b0;
    shift_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          bit_cnt_d  = '0;
          acc_d      = '0;
          word_rem_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (shift_en_q) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        // A new word can land on the same edge the previous word's last bit leaves.
        if (accept_s) begin
          head_d     = cfg_data[0];
          sreg_d     = cfg_data >> 1;
          shift_en_d = 1'b1;
          word_rem_d = REM_W'(take_s - MW'(1));
          acc_d      = acc_q + CNT_W'(take_s);
        end else if (shift_en_q && (word_rem_q != '0)) begin
          head_d     = sreg_q[0];
          sreg_d     = sreg_q >> 1;
          shift_en_d = 1'b1;
          word_rem_d = word_rem_q - REM_W'(1);
        end else begin
          head_d     = 1'b0;
          shift_en_d = 1'b0;
        end
        if (last_shift_s) begin
`ifdef CCFF_READBACK_EN
          state_d    = ST_VERIFY;
          bit_cnt_d  = '0;
          shift_en_d = 1'b1;
`else
          state_d    = ST_DONE;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_VERIFY: begin
`ifdef CCFF_READBACK_EN
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        shift_en_d = 1'b1;
        if (last_shift_s) begin
          state_d    = ST_DONE;
          shift_en_d = 1'b0;
        end else begin
          state_d = ST_VERIFY;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_LOAD) && (acc_d != CHAIN_LEN_C) &&
              (!shift_en_d || (word_rem_d == '0));
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      word_rem_q <= '0;
      sreg_q     <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      word_rem_q <= word_rem_d;
      sreg_q     <= sreg_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cfg_ready     = ready_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_load_s;
  logic [15:0] unused_crc_load_next_s;
  logic [15:0] unused_crc_tail_s;
  logic [15:0] crc_tail_next_s;
  logic        verify_fail_q, verify_fail_d;

  ccff_crc16_serial u_crc_load (
    .clk      (prog_clk),
    .rst_n    (pReset),
    .clr      (start_ok_s),
    .en       ((state_q == ST_LOAD) && shift_en_q),
    .din      (head_q),
    .crc      (crc_load_s),
    .crc_next (unused_crc_load_next_s)
  );

  ccff_crc16_serial u_crc_tail (
    .clk      (prog_clk),
    .rst_n    (pReset),
    .clr      (start_ok_s),
    .en       (state_q == ST_VERIFY),
    .din      (ccff_tail),
    .crc      (unused_crc_tail_s),
    .crc_next (crc_tail_next_s)
  );

  // Compare against the tail CRC including the bit returning on the final verify cycle.
  always_comb begin
    crc_fail_s = (crc_load_s != crc_tail_next_s);
    if (start_ok_s) begin
      verify_fail_d = 1'b0;
    end else if ((state_q == ST_VERIFY) && last_shift_s) begin
      verify_fail_d = crc_fail_s;
    end else begin
      verify_fail_d = verify_fail_q;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      verify_fail_q <= 1'b0;
    end else begin
      verify_fail_q <= verify_fail_d;
    end
  end

  // During readback the chain is closed into a loop so it ends up in its loaded state.
  assign ccff_head   = (state_q == ST_VERIFY) ? ccff_tail : head_q;
  assign verify_fail = verify_fail_q;
`else
  logic unused_tail_s;
  logic unused_start_ok_s;
  assign unused_tail_s     = ccff_tail;
  assign unused_start_ok_s = start_ok_s;
  assign ccff_head         = head_q;
  assign verify_fail       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 48-bit and a 20-bit chain, each with a shift-register chain model.
module tb_ccff_chain_loader;

  localparam int N0 = 48;
  localparam int N1 = 20;
  localparam int DW = 8;
`ifdef CCFF_READBACK_EN
  localparam int LAT0 = N0 + 1;
  localparam int LAT1 = N1 + 1;
  localparam int VS0  = N0;
  localparam int VS1  = N1;
`else
  localparam int LAT0 = 1;
  localparam int LAT1 = 1;
  localparam int VS0  = 0;
  localparam int VS1  = 0;
`endif

  logic prog_clk = 1'b0;
  logic pReset;
  logic [1:0] start, cfg_valid, cfg_ready, head, shen, tail, busy, done, vfail;
  logic [1:0][DW-1:0] data_s;
  logic [N0-1:0] chain0 = '0;
  logic [N0-1:0] flip0;
  logic [N1-1:0] chain1 = '0;
  logic [7:0] words [8];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] rec_bits;
  int rec_shifts, rec_vshifts, rec_first, rec_last, rec_done, rec_start, rec_accepted, rec_ready_late;
  logic rec_vf, rec_busy_at_done;

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Chain model: bit enters at index 0, leaves from the top index.
  always @(posedge prog_clk) begin
    if (shen[0]) chain0 <= {chain0[N0-2:0], head[0]} ^ flip0;
    if (shen[1]) chain1 <= {chain1[N1-2:0], head[1]};
  end
  assign tail[0] = chain0[N0-1];
  assign tail[1] = chain1[N1-1];

  ccff_chain_loader #(.CHAIN_LEN(N0), .DATA_W(DW)) dut0 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start[0]), .cfg_data(data_s[0]),
    .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]), .ccff_head(head[0]),
    .ccff_shift_en(shen[0]), .ccff_tail(tail[0]), .busy(busy[0]), .done(done[0]),
    .verify_fail(vfail[0]));

  ccff_chain_loader #(.CHAIN_LEN(N1), .DATA_W(DW)) dut1 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start[1]), .cfg_data(data_s[1]),
    .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]), .ccff_head(head[1]),
    .ccff_shift_en(shen[1]), .ccff_tail(tail[1]), .busy(busy[1]), .done(done[1]),
    .verify_fail(vfail[1]));

  function automatic logic [63:0] exp_bits(input int nlen);
    logic [63:0] e;
    logic [7:0] w;
    e = '0;
    for (int j = 0; j < nlen; j++) begin
      w = words[j / 8];
      e[j] = w[j % 8];
    end
    return e;
  endfunction

  function automatic logic [63:0] exp_chain(input int nlen);
    logic [63:0] e, c;
    e = exp_bits(nlen);
    c = '0;
    for (int j = 0; j < nlen; j++) c[nlen - 1 - j] = e[j];
    return c;
  endfunction

  task automatic run_load(input int sel, input int nlen, input int nw, input int gap_at,
                          input int gap_len, input int pulse_at, input bit do_flip);
    int wi, gcnt, shifts;
    bit flipped, gap_active, acc;
    wi = 0; gcnt = 0; shifts = 0; flipped = 1'b0;
    rec_bits = '0; rec_vshifts = 0; rec_first = -1; rec_last = -1; rec_done = -1;
    rec_vf = 1'b0; rec_busy_at_done = 1'b1; rec_ready_late = 0;
    start[sel] = 1'b1;
    rec_start = cyc;
    @(posedge prog_clk); #1;
    start[sel] = 1'b0;
    checks++;
    if (!(busy[sel] === 1'b1 && cfg_ready[sel] === 1'b1 && vfail[sel] === 1'b0)) begin
      failures++;
      $display("FAIL start_response sel=%0d busy/ready/vfail got=%b%b%b expected=110",
               sel, busy[sel], cfg_ready[sel], vfail[sel]);
    end
    for (int t = 0; t < 400 && rec_done < 0; t++) begin
      if (shen[sel] === 1'b1) begin
        if (shifts < nlen) begin
          rec_bits[shifts] = head[sel];
          if (rec_first < 0) rec_first = cyc;
          shifts++;
          if (shifts == nlen) rec_last = cyc;
        end else begin
          rec_vshifts++;
        end
      end
      if (wi >= nw && cfg_ready[sel] === 1'b1) rec_ready_late++;
      if (done[sel] === 1'b1) begin
        rec_done = cyc;
        rec_busy_at_done = busy[sel];
        rec_vf = vfail[sel];
      end
      start[sel] = (t == pulse_at);
      flip0 = '0;
      if (do_flip && rec_last >= 0 && !flipped) begin
        flip0[5] = 1'b1;
        flipped = 1'b1;
      end
      gap_active = (wi == gap_at) && (gcnt < gap_len);
      if (gap_active && cfg_ready[sel] === 1'b1) gcnt++;
      cfg_valid[sel] = (wi < nw) && !gap_active;
      data_s[sel] = words[(wi < 8) ? wi : 0];
      acc = cfg_valid[sel] && (cfg_ready[sel] === 1'b1);
      @(posedge prog_clk); #1;
      if (acc) wi++;
    end
    cfg_valid[sel] = 1'b0;
    start[sel] = 1'b0;
    flip0 = '0;
    rec_shifts = shifts;
    rec_accepted = wi;
    checks++;
    if (rec_done < 0) begin
      failures++;
      $display("FAIL done_timeout sel=%0d shifts=%0d expected done pulse", sel, shifts);
    end
  endtask

  task automatic test_reset;
    pReset = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({cfg_ready[s], head[s], shen[s], busy[s], done[s], vfail[s]} !== 6'b0) begin
        failures++;
        $display("FAIL reset_values sel=%0d got=%b%b%b%b%b%b expected=000000", s,
                 cfg_ready[s], head[s], shen[s], busy[s], done[s], vfail[s]);
      end
    end
    pReset = 1'b1;
    cfg_valid = 2'b11;
    data_s[0] = 8'hFF;
    repeat (2) @(posedge prog_clk);
    #1;
    checks++;
    if ({cfg_ready[0], shen[0], busy[0], head[0]} !== 4'b0) begin
      failures++;
      $display("FAIL idle_ignores_valid got=%b%b%b%b expected=0000",
               cfg_ready[0], shen[0], busy[0], head[0]);
    end
    cfg_valid = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [63:0] ec;
    words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    run_load(0, N0, 6, -1, 0, -1, 1'b0);
    ec = exp_chain(N0);
    checks++;
    if (rec_bits !== exp_bits(N0)) begin
      failures++; $display("FAIL b2b_head_seq got=%h expected=%h", rec_bits, exp_bits(N0));
    end
    checks++;
    if (rec_last - rec_first + 1 != N0) begin
      failures++; $display("FAIL b2b_contiguous span=%0d expected=%0d", rec_last - rec_first + 1, N0);
    end
    checks++;
    if (rec_done - rec_last != LAT0) begin
      failures++; $display("FAIL b2b_done_latency got=%0d expected=%0d", rec_done - rec_last, LAT0);
    end
    checks++;
    if (rec_vshifts != VS0 || rec_vf !== 1'b0 || rec_busy_at_done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_finish vshifts=%0d vf=%b busy=%b expected=%0d 0 0",
               rec_vshifts, rec_vf, rec_busy_at_done, VS0);
    end
    checks++;
    if (chain0 !== ec[N0-1:0]) begin
      failures++; $display("FAIL b2b_chain got=%h expected=%h", chain0, ec[N0-1:0]);
    end
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0 || rec_ready_late != 0) begin
      failures++;
      $display("FAIL b2b_after done=%b busy=%b late_ready=%0d expected=0 0 0",
               done[0], busy[0], rec_ready_late);
    end
  endtask

  task automatic test_truncate;
    logic [63:0] ec;
    words = '{8'hFF, 8'hFF, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(1, N1, 3, -1, 0, -1, 1'b0);
    ec = exp_chain(N1);
    checks++;
    if (rec_shifts != N1 || rec_bits !== 64'h0000_0000_000B_FFFF) begin
      failures++;
      $display("FAIL trunc_head_seq shifts=%0d bits=%h expected=%0d 00000000000bffff",
               rec_shifts, rec_bits, N1);
    end
    checks++;
    if (rec_bits[19:16] !== 4'b1011 || rec_accepted != 3 || rec_ready_late != 0) begin
      failures++;
      $display("FAIL trunc_tail_bits got=%b acc=%0d late_ready=%0d expected=1011 3 0",
               rec_bits[19:16], rec_accepted, rec_ready_late);
    end
    checks++;
    if (rec_done - rec_last != LAT1 || rec_vshifts != VS1) begin
      failures++;
      $display("FAIL trunc_done_latency got=%0d vsh=%0d expected=%0d %0d",
               rec_done - rec_last, rec_vshifts, LAT1, VS1);
    end
    checks++;
    if (chain1 !== ec[N1-1:0]) begin
      failures++; $display("FAIL trunc_chain got=%h expected=%h", chain1, ec[N1-1:0]);
    end
  endtask

  task automatic test_starvation;
    logic [63:0] ec;
    words = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'h00, 8'h00};
    run_load(0, N0, 6, 3, 3, -1, 1'b0);
    ec = exp_chain(N0);
    checks++;
    if (rec_last - rec_first + 1 - N0 != 3) begin
      failures++; $display("FAIL starve_bubbles got=%0d expected=3", rec_last - rec_first + 1 - N0);
    end
    checks++;
    if (rec_bits !== exp_bits(N0) || chain0 !== ec[N0-1:0]) begin
      failures++;
      $display("FAIL starve_data bits=%h chain=%h expected=%h %h",
               rec_bits, chain0, exp_bits(N0), ec[N0-1:0]);
    end
    checks++;
    if (rec_done - rec_last != LAT0) begin
      failures++; $display("FAIL starve_done_latency got=%0d expected=%0d", rec_done - rec_last, LAT0);
    end
  endtask

  task automatic test_start_during_load;
    words = '{8'hC3, 8'h5A, 8'hE1, 8'h7E, 8'h81, 8'h24, 8'h00, 8'h00};
    run_load(0, N0, 6, -1, 0, 10, 1'b0);
    checks++;
    if (rec_shifts != N0 || rec_first - rec_start != 2) begin
      failures++;
      $display("FAIL restart_shifts shifts=%0d first_ofs=%0d expected=%0d 2",
               rec_shifts, rec_first - rec_start, N0);
    end
    checks++;
    if (rec_done - rec_start != N0 + 1 + LAT0) begin
      failures++;
      $display("FAIL restart_done_time got=%0d expected=%0d", rec_done - rec_start, N0 + 1 + LAT0);
    end
  endtask

  task automatic test_reset_midload;
    int shifts, wi;
    bit acc;
    logic [63:0] ec;
    shifts = 0; wi = 0;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00};
    start[0] = 1'b1;
    @(posedge prog_clk); #1;
    start[0] = 1'b0;
    for (int t = 0; t < 60 && shifts < 13; t++) begin
      if (shen[0] === 1'b1) shifts++;
      if (shifts < 13) begin
        cfg_valid[0] = (wi < 6);
        data_s[0] = words[(wi < 6) ? wi : 0];
        acc = cfg_valid[0] && (cfg_ready[0] === 1'b1);
        @(posedge prog_clk); #1;
        if (acc) wi++;
      end
    end
    checks++;
    if (shifts != 13) begin
      failures++; $display("FAIL midreset_shift_count got=%0d expected=13", shifts);
    end
    pReset = 1'b0;
    #1;
    checks++;
    if ({cfg_ready[0], head[0], shen[0], busy[0], done[0], vfail[0]} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_async got=%b%b%b%b%b%b expected=000000",
               cfg_ready[0], head[0], shen[0], busy[0], done[0], vfail[0]);
    end
    cfg_valid[0] = 1'b0;
    @(posedge prog_clk); #1;
    pReset = 1'b1;
    @(posedge prog_clk); #1;
    checks++;
    if ({busy[0], shen[0], cfg_ready[0]} !== 3'b0) begin
      failures++; $display("FAIL midreset_idle got=%b%b%b expected=000", busy[0], shen[0], cfg_ready[0]);
    end
    words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    run_load(0, N0, 6, -1, 0, -1, 1'b0);
    ec = exp_chain(N0);
    checks++;
    if (rec_bits !== exp_bits(N0) || chain0 !== ec[N0-1:0] || rec_done - rec_start != N0 + 1 + LAT0) begin
      failures++;
      $display("FAIL midreset_reload chain=%h done_ofs=%0d expected=%h %0d",
               chain0, rec_done - rec_start, ec[N0-1:0], N0 + 1 + LAT0);
    end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_verify_fault;
    logic [63:0] ec;
    words = '{8'h9E, 8'h37, 8'h79, 8'hB9, 8'h7F, 8'h4A, 8'h00, 8'h00};
    run_load(0, N0, 6, -1, 0, -1, 1'b1);
    checks++;
    if (rec_vf !== 1'b1 || rec_vshifts != N0) begin
      failures++; $display("FAIL verify_detect vf=%b vsh=%0d expected=1 %0d", rec_vf, rec_vshifts, N0);
    end
    checks++;
    if (vfail[0] !== 1'b1) begin
      failures++; $display("FAIL verify_hold got=%b expected=1", vfail[0]);
    end
    run_load(0, N0, 6, -1, 0, -1, 1'b0);
    ec = exp_chain(N0);
    checks++;
    if (rec_vf !== 1'b0 || chain0 !== ec[N0-1:0]) begin
      failures++;
      $display("FAIL verify_clean vf=%b chain=%h expected=0 %h", rec_vf, chain0, ec[N0-1:0]);
    end
  endtask
`endif

  initial begin
    start = '0;
    cfg_valid = '0;
    data_s = '0;
    flip0 = '0;
    pReset = 1'b0;
    test_reset();
    test_back_to_back();
    test_truncate();
    test_starvation();
    test_start_during_load();
    test_reset_midload();
`ifdef CCFF_READBACK_EN
    test_verify_fault();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
